// File: rtl/ssp_fifo_flags_if.sv
// ssp_fifo_flags_if: push/pop strobes, FIFO data and status flags exchanged
// between the SSP FIFO pair and its users (APB register file, serial core,
// DMA request logic). The slave modport is the FIFO block side.
interface ssp_fifo_flags_if #(
    parameter int DW = 16
);
    logic          TXWrite;
    logic [DW-1:0] PWDATA;
    logic          TXRead;
    logic [DW-1:0] TXData;
    logic          RXWrite;
    logic [DW-1:0] RXWData;
    logic          RXRead;
    logic [DW-1:0] RXData;
    logic          RORClr;
    logic          TXDMACLR;
    logic          RXDMACLR;
    logic          TXRIS;
    logic          RXRIS;
    logic          TXFLTE7Full;
    logic          RXFGTE1Full;
    logic          TFE;
    logic          TNF;
    logic          RNE;
    logic          RFF;
    logic          RORRIS;
    logic          IntTXDMACLRSync;
    logic          IntRXDMACLRSync;

    modport slave (
        input  TXWrite, PWDATA, TXRead, RXWrite, RXWData, RXRead,
               RORClr, TXDMACLR, RXDMACLR,
        output TXData, RXData, TXRIS, RXRIS, TXFLTE7Full, RXFGTE1Full,
               TFE, TNF, RNE, RFF, RORRIS, IntTXDMACLRSync, IntRXDMACLRSync
    );

    modport master (
        output TXWrite, PWDATA, TXRead, RXWrite, RXWData, RXRead,
               RORClr, TXDMACLR, RXDMACLR,
        input  TXData, RXData, TXRIS, RXRIS, TXFLTE7Full, RXFGTE1Full,
               TFE, TNF, RNE, RFF, RORRIS, IntTXDMACLRSync, IntRXDMACLRSync
    );
endinterface

// File: rtl/ssp_fifo_flags.sv
// ssp_fifo_flags: SSP transmit/receive FIFO pair with occupancy flags,
// sticky receive-overrun status and DMA clear pulse generation.
// Optional feature macro: SSP_DMACLR_SYNC_EN -- when defined, TXDMACLR and
// RXDMACLR pass through a two-flop synchroniser before edge detection
// (pulse 3 PCLK edges after the input rises instead of 1).

// Single 8-entry FIFO: full pushes are refused (a same-cycle pop does not
// make room), empty pops are ignored, head reads zero when empty.
module ssp_fifo_flags_fifo #(
    parameter int  DW    = 16,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [CW-1:0] count
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    // Accept/ignore decisions and next pointer/count values
    always_comb begin
        push_ok = push && (count_q != CW'(DEPTH));
        pop_ok  = pop && (count_q != '0);
        wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop_ok ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointer and count registers, cleared asynchronously
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage, deliberately not reset
    always_ff @(posedge PCLK) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata = (count_q != '0) ? mem_q[rptr_q] : '0;
    assign count = count_q;
endmodule

module ssp_fifo_flags #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic           PCLK,
    input  logic           PRESETn,
    ssp_fifo_flags_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic          rx_reject;
    logic          ror_q, ror_d;
    logic [1:0]    clr_in;
    logic [1:0]    clr_pulse;

    ssp_fifo_flags_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .push    (bus.TXWrite),
        .pop     (bus.TXRead),
        .wdata   (bus.PWDATA),
        .rdata   (bus.TXData),
        .count   (tx_count)
    );

    ssp_fifo_flags_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .push    (bus.RXWrite),
        .pop     (bus.RXRead),
        .wdata   (bus.RXWData),
        .rdata   (bus.RXData),
        .count   (rx_count)
    );

    // Flags decode straight from the registered counts
    assign bus.TXRIS       = (tx_count <= CW'(DEPTH / 2));
    assign bus.TXFLTE7Full = (tx_count <= CW'(DEPTH - 1));
    assign bus.TFE         = (tx_count == '0);
    assign bus.TNF         = (tx_count != CW'(DEPTH));
    assign bus.RXRIS       = (rx_count >= CW'(DEPTH / 2));
    assign bus.RXFGTE1Full = (rx_count >= CW'(1));
    assign bus.RNE         = (rx_count != '0);
    assign bus.RFF         = (rx_count == CW'(DEPTH));

    // Overrun is set by a push into a full RX FIFO; set beats clear
    always_comb begin
        rx_reject = bus.RXWrite && (rx_count == CW'(DEPTH));
        ror_d     = rx_reject | (ror_q & ~bus.RORClr);
    end

    // Sticky overrun status register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ror_q <= 1'b0;
        end else begin
            ror_q <= ror_d;
        end
    end

    assign bus.RORRIS = ror_q;

    // Channel 0 is TX, channel 1 is RX
    assign clr_in              = {bus.RXDMACLR, bus.TXDMACLR};
    assign bus.IntTXDMACLRSync = clr_pulse[0];
    assign bus.IntRXDMACLRSync = clr_pulse[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_clr
`ifdef SSP_DMACLR_SYNC_EN
            logic sync1_q, sync1_d, sync2_q, sync2_d;
            logic dly_q, dly_d, pulse_q, pulse_d;

            // Two-flop synchroniser, then rising-edge detect against a delayed copy
            always_comb begin
                sync1_d = clr_in[gi];
                sync2_d = sync1_q;
                dly_d   = sync2_q;
                pulse_d = sync2_q & ~dly_q;
            end

            // Synchroniser, delay and pulse registers
            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    dly_q   <= 1'b0;
                    pulse_q <= 1'b0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    dly_q   <= dly_d;
                    pulse_q <= pulse_d;
                end
            end
`else
            logic dly_q, dly_d, pulse_q, pulse_d;

            // Input is already PCLK-synchronous: edge detect against one register stage
            always_comb begin
                dly_d   = clr_in[gi];
                pulse_d = clr_in[gi] & ~dly_q;
            end

            // Delay and pulse registers
            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) begin
                    dly_q   <= 1'b0;
                    pulse_q <= 1'b0;
                end else begin
                    dly_q   <= dly_d;
                    pulse_q <= pulse_d;
                end
            end
`endif
            assign clr_pulse[gi] = pulse_q;
        end
    endgenerate
endmodule
